// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: issues one outstanding imem request at a time and
// buffers returned words with their PCs in a small circular prefetch queue.
module fetch_prefetch #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 pc_sel,
  input  logic [XLEN-1:0]            jal_br_target,
  input  logic [XLEN-1:0]            jr_target,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [31:0]                imem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic [XLEN-1:0]            pc_plus_4_out,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 fsm_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            grant;
  logic            push;
  logic            pop;
  logic [31:0]     q_data [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Handshakes: a request transfers when imem_req && imem_gnt; a queue entry
  // transfers to the consumer when inst_valid && inst_ready.
  assign redirect      = (pc_sel == 2'b01) || (pc_sel == 2'b10);
  assign target        = (pc_sel == 2'b01) ? jal_br_target : jr_target;
  assign imem_req      = !rst && (state == IDLE) && (count < FULL);
  assign imem_addr     = fetch_pc;
  assign grant         = imem_req && imem_gnt;
  assign push          = (state == WAIT) && imem_rvalid && !redirect;
  assign inst_valid    = (count != '0);
  assign pop           = inst_valid && inst_ready;
  assign inst          = q_data[rd_ptr];
  assign inst_pc       = q_pc[rd_ptr];
  assign pc_plus_4_out = q_pc[rd_ptr] + XLEN'(4);
  assign fsm_state     = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = redirect ? DISCARD : WAIT;
      WAIT: begin
        if (imem_rvalid)   state_nxt = IDLE;
        else if (redirect) state_nxt = DISCARD;
      end
      // The stale response still has to drain before a new request goes out.
      DISCARD: if (imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (redirect)   fetch_pc <= {target[XLEN-1:2], 2'b00};
      else if (grant) fetch_pc <= fetch_pc + XLEN'(4);
      if (grant) req_pc <= fetch_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: transaction-level model of the fetch stream and
// queue, per-cycle compare, and directed scenarios with literal expectations.
module tb_fetch_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] jal_br_target, jr_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc, pc_plus_4_out;
  logic [2:0]  count;
  logic [1:0]  fsm_state;

  logic        w_imem_req, w_imem_rvalid, w_inst_valid;
  logic [31:0] w_imem_addr, w_inst, w_inst_pc, w_pc_plus_4_out;
  logic [2:0]  w_count;
  logic [1:0]  w_fsm_state;

  always #5 clk = ~clk;

  fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .jal_br_target(jal_br_target),
    .jr_target(jr_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .pc_plus_4_out(pc_plus_4_out), .count(count),
    .fsm_state(fsm_state)
  );

  fetch_prefetch #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst), .pc_sel(2'b00), .jal_br_target(32'h0),
    .jr_target(32'h0), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_gnt(1'b1), .imem_rvalid(w_imem_rvalid), .imem_rdata(32'h0000_600D),
    .inst_valid(w_inst_valid), .inst_ready(1'b0), .inst(w_inst),
    .inst_pc(w_inst_pc), .pc_plus_4_out(w_pc_plus_4_out), .count(w_count),
    .fsm_state(w_fsm_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Memory responder: grant is driven by the stimulus, data returns lat cycles after it.
  int          lat = 1;
  int          resp_cnt = 0;
  logic [31:0] resp_addr;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic        g_seen = 1'b0;
  logic [31:0] g_addr;
  logic [31:0] addr_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_p4_log[$];
  int          max_cnt = 0;
  bit          junk_seen = 0;

  always @(negedge clk) begin
    g_seen = imem_req && imem_gnt;
    g_addr = imem_addr;
    if (g_seen) addr_log.push_back(imem_addr);
    if (inst_valid && inst_ready) begin
      pop_pc_log.push_back(inst_pc);
      pop_p4_log.push_back(pc_plus_4_out);
    end
    if (int'(count) > max_cnt) max_cnt = int'(count);
    if (inst_valid && (inst == 32'h0000_DEAD || inst == 32'h0000_BEEF)) junk_seen = 1;
  end

  always @(posedge clk) begin
    #1;
    imem_rvalid = 1'b0;
    if (g_seen) begin
      resp_cnt  = lat;
      resp_addr = g_addr;
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = ovr_en ? ovr_data : (resp_addr ^ 32'h5A5A_0000);
      end
    end
  end

  logic        w_g = 1'b0;
  logic [31:0] w_addr_log[$];
  bit          w_first_seen = 0;
  logic [31:0] w_first_pc, w_first_p4;

  always @(negedge clk) begin
    w_g = w_imem_req;
    if (w_g && w_addr_log.size() < 2) w_addr_log.push_back(w_imem_addr);
    if (w_inst_valid && !w_first_seen) begin
      w_first_seen = 1;
      w_first_pc   = w_inst_pc;
      w_first_p4   = w_pc_plus_4_out;
    end
  end

  always @(posedge clk) begin
    #1;
    w_imem_rvalid = w_g;
  end

  // Model: the fetch stream is a PC plus at most one in-flight request that is
  // either live or stale; the queue holds {data, pc} of live returns in order.
  logic [63:0] exp_q[$];
  logic [31:0] m_fpc = 32'h0;
  logic [31:0] m_pend_pc = 32'h0;
  bit          m_pend = 0;
  bit          m_stale = 0;

  always @(posedge clk) begin : model
    bit          redir, req, grant, rv, pop;
    logic [31:0] tgt;
    if (rst) begin
      exp_q.delete();
      m_fpc   = 32'h0;
      m_pend  = 0;
      m_stale = 0;
    end else begin
      redir = (pc_sel == 2'b01) || (pc_sel == 2'b10);
      tgt   = ((pc_sel == 2'b01) ? jal_br_target : jr_target) & ~32'h3;
      req   = !m_pend && exp_q.size() < DEPTH;
      grant = req && imem_gnt;
      rv    = m_pend && imem_rvalid;
      pop   = exp_q.size() > 0 && inst_ready;
      if (redir) exp_q.delete();
      else begin
        if (pop) void'(exp_q.pop_front());
        if (rv && !m_stale) exp_q.push_back({imem_rdata, m_pend_pc});
      end
      if (rv) m_pend = 0;
      else if (m_pend && redir) m_stale = 1;
      if (grant) begin
        m_pend    = 1;
        m_stale   = redir;
        m_pend_pc = m_fpc;
      end
      if (redir)      m_fpc = tgt;
      else if (grant) m_fpc = m_fpc + 32'd4;
    end
  end

  always @(negedge clk) begin : compare
    logic        m_req;
    logic [1:0]  m_state;
    if (chk_en) begin
      m_req   = !rst && !m_pend && exp_q.size() < DEPTH;
      m_state = !m_pend ? 2'd0 : (m_stale ? 2'd2 : 2'd1);
      chk("cyc_count", 32'(count), 32'(exp_q.size()));
      chk("cyc_valid", 32'(inst_valid), 32'(exp_q.size() > 0));
      chk("cyc_req", 32'(imem_req), 32'(m_req));
      chk("cyc_state", 32'(fsm_state), 32'(m_state));
      if (m_req) chk("cyc_addr", imem_addr, m_fpc);
      if (exp_q.size() > 0) begin
        chk("cyc_inst", inst, exp_q[0][63:32]);
        chk("cyc_pc", inst_pc, exp_q[0][31:0]);
        chk("cyc_pc4", pc_plus_4_out, exp_q[0][31:0] + 32'd4);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic expect_first_addr(input string name, input logic [31:0] expv);
    int n = 0;
    while (addr_log.size() == 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, (addr_log.size() > 0) ? addr_log[0] : 32'hxxxx_xxxx, expv);
  endtask

  initial begin
    rst = 1'b1; pc_sel = 2'b00; jal_br_target = 32'h0; jr_target = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; inst_ready = 1'b0;
    step(1);
    chk_en = 1;
    step(1);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    step(1);

    // Fill
    imem_gnt = 1'b1; lat = 1; inst_ready = 1'b0;
    do_reset();
    addr_log.delete();
    step(14);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fill_addr%0d", i), (i < addr_log.size()) ? addr_log[i] : 32'hxxxx_xxxx, 32'(i * 4));
    chk("fill_nreq", 32'(addr_log.size()), 32'd4);
    chk("fill_req_low", 32'(imem_req), 32'h0);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_head_pc", inst_pc, 32'h0);

    // Streaming
    step(1);
    inst_ready = 1'b1;
    do_reset();
    pop_pc_log.delete(); pop_p4_log.delete(); max_cnt = 0;
    step(14);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stream_pc%0d", i), (i < pop_pc_log.size()) ? pop_pc_log[i] : 32'hxxxx_xxxx, 32'(i * 4));
      chk($sformatf("stream_p4_%0d", i), (i < pop_p4_log.size()) ? pop_p4_log[i] : 32'hxxxx_xxxx, 32'(i * 4 + 4));
    end
    chk("stream_maxcnt", 32'(max_cnt <= 1), 32'h1);

    // Redirect with three entries queued
    step(1);
    inst_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 30 && exp_q.size() != 3; i++) step(1);
    chk("redir_reach3", 32'(exp_q.size()), 32'd3);
    pc_sel = 2'b01; jal_br_target = 32'h0000_0100;
    step(1);
    pc_sel = 2'b00;
    addr_log.delete();
    @(negedge clk);
    chk("redir_valid", 32'(inst_valid), 32'h0);
    chk("redir_count", 32'(count), 32'h0);
    expect_first_addr("redir_addr", 32'h0000_0100);

    // Redirect while waiting; stale 0xDEAD must be dropped
    step(1);
    inst_ready = 1'b1; lat = 3;
    do_reset();
    for (int i = 0; i < 30 && !(m_pend && !m_stale); i++) step(1);
    junk_seen = 0;
    pc_sel = 2'b10; jr_target = 32'h0000_0202; ovr_en = 1'b1; ovr_data = 32'h0000_DEAD;
    step(1);
    pc_sel = 2'b00;
    addr_log.delete();
    expect_first_addr("discard_addr", 32'h0000_0200);
    chk("discard_count", 32'(count), 32'h0);
    chk("discard_no_dead", 32'(junk_seen), 32'h0);
    ovr_en = 1'b0;

    // Reset mid-wait; late 0xBEEF arrives while idle
    step(1);
    inst_ready = 1'b0; lat = 3;
    do_reset();
    for (int i = 0; i < 30 && !m_pend; i++) step(1);
    ovr_en = 1'b1; ovr_data = 32'h0000_BEEF; junk_seen = 0;
    imem_gnt = 1'b0;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(5);
    @(negedge clk);
    chk("rstw_count", 32'(count), 32'h0);
    chk("rstw_no_beef", 32'(junk_seen), 32'h0);
    addr_log.delete();
    ovr_en = 1'b0;
    imem_gnt = 1'b1;
    expect_first_addr("rstw_addr", 32'h0);

    // Address wrap on the second instance
    chk("wrap_addr0", (w_addr_log.size() > 0) ? w_addr_log[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    chk("wrap_addr1", (w_addr_log.size() > 1) ? w_addr_log[1] : 32'hxxxx_xxxx, 32'h0);
    chk("wrap_pc", w_first_seen ? w_first_pc : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
    chk("wrap_pc4", w_first_seen ? w_first_p4 : 32'hxxxx_xxxx, 32'h0);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 The parameter XLEN SHALL default to 32 and set the address and PC width.
REQ-002 The parameter DEPTH SHALL default to 4 and set the prefetch queue entries (power of two, >=2).
REQ-003 The parameter RESET_PC SHALL default to 32'h0 and set the PC loaded at reset.
REQ-004 The module SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 pc_sel  in  2  redirect select: 01 uses jal_br_target, 10 uses jr_target, 00 and 11 mean no redirect.
REQ-008 jal_br_target  in  XLEN  branch/JAL target.
REQ-009 jr_target  in  XLEN  JR target.
REQ-010 imem_req  out  1  instruction-memory request valid.
REQ-011 imem_addr  out  XLEN  request address, equal to fetch_pc.
REQ-012 imem_gnt  in  1  request accepted this cycle.
REQ-013 imem_rvalid  in  1  read data valid; arrives >=1 cycle after grant.
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 inst_valid  out  1  queue head valid.
REQ-016 inst_ready  in  1  consumer accepts head.
REQ-017 inst  out  32  head instruction.
REQ-018 inst_pc  out  XLEN  head PC.
REQ-019 pc_plus_4_out  out  XLEN  inst_pc+4, modulo 2^XLEN.
REQ-020 count  out  $clog2(DEPTH+1)  queue occupancy.

Function
REQ-021 The FSM SHALL have the states IDLE, WAIT and DISCARD, with at most one outstanding memory request.
REQ-022 In IDLE, imem_req SHALL be 1 iff count<DEPTH; in WAIT and DISCARD it SHALL be 0.
REQ-023 An IDLE grant without redirect SHALL latch req_pc=fetch_pc, set fetch_pc+=4 (wraps modulo 2^XLEN) and go to WAIT.
REQ-024 rvalid in WAIT without redirect SHALL push {imem_rdata, req_pc} to the queue tail and return to IDLE; a new request may be issued the following cycle.
REQ-025 rvalid in DISCARD SHALL drop the data and return to IDLE.
REQ-026 rvalid in IDLE SHALL be ignored.
REQ-027 Pop SHALL occur on inst_valid && inst_ready.
REQ-028 A simultaneous push and pop SHALL leave count unchanged.
REQ-029 The queue SHALL be circular with read/write pointers wrapping at DEPTH.
REQ-030 Queue outputs SHALL be driven from the head entry, with zero added latency (data visible the cycle after the push).
REQ-031 A redirect (pc_sel 01/10) in any state SHALL set fetch_pc to the target with bits [1:0] forced to 0.
REQ-032 A redirect SHALL empty the queue, so that inst_valid=0 and count=0 in the next cycle; the flush overrides a same-cycle push or pop.
REQ-033 A redirect in WAIT without same-cycle rvalid SHALL move the FSM to DISCARD.
REQ-034 A redirect in WAIT with same-cycle rvalid SHALL drop the data and move the FSM to IDLE.
REQ-035 A redirect in IDLE with same-cycle grant SHALL move the FSM to DISCARD; the granted stale address is dropped.
REQ-036 A redirect in DISCARD SHALL update fetch_pc and keep the FSM in DISCARD.
REQ-037 The queue SHALL never overflow (request only when count<DEPTH, one outstanding); push when full is impossible by construction.
REQ-038 inst, inst_pc and pc_plus_4_out SHALL be don't-care while inst_valid=0.

Reset
REQ-039 rst=1 SHALL set fetch_pc=RESET_PC, the state to IDLE, the queue pointers and count to 0, inst_valid=0 and imem_req=0 during reset.
REQ-040 rst SHALL override a redirect, grant, rvalid and pop in the same cycle.
REQ-041 rst asserted mid-WAIT SHALL abandon the outstanding request, and its late rvalid (arriving in IDLE) SHALL be ignored.

Verification
REQ-042 Fill test (DEPTH=4, RESET_PC=0, gnt=1, rvalid 1 cycle after grant, inst_ready=0): imem_addr sequence SHALL be 0,4,8,C, after which imem_req=0 and count=4.
REQ-043 Streaming test (inst_ready=1): inst_pc SHALL read 0,4,8,C with pc_plus_4_out 4,8,C,10, and count SHALL stay <=1.
REQ-044 Redirect test (count=3, pc_sel=01, jal_br_target=0x100): the next cycle SHALL have inst_valid=0 and count=0, and the next imem_addr SHALL be 0x100.
REQ-045 Discard test (pc_sel=10, jr_target=0x202 during WAIT, rvalid two cycles later with 0xDEAD): the word SHALL not be enqueued, and the next imem_addr SHALL be 0x200.
REQ-046 Wrap test (RESET_PC=0xFFFFFFFC): the second imem_addr SHALL be 0x0, and the first pc_plus_4_out SHALL be 0x0.
REQ-047 Reset mid-WAIT test (rst pulsed, then stale rvalid with 0xBEEF): count SHALL stay 0, and the first imem_addr after reset SHALL be RESET_PC.
